// File: rtl/memory_types_pkg.sv
// Shared memory-port types: request/response packet, access type,
// length encoding and the byte-mask helper used by the memory responder.
package memory_types_pkg;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } mem_type_e;

  // len field: 0 selects a full word, otherwise the byte count
  localparam logic [1:0] LEN_WORD = 2'd0;
  localparam logic [1:0] LEN_1B   = 2'd1;
  localparam logic [1:0] LEN_2B   = 2'd2;
  localparam logic [1:0] LEN_3B   = 2'd3;

  typedef struct packed {
    mem_type_e   mtype;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_pkt_t;

  // Bytes offset..offset+n-1 of the addressed word; bytes past byte 3 are dropped
  function automatic logic [3:0] len_to_bytemask(input logic [1:0] len,
                                                 input logic [1:0] offset);
    logic [7:0] span;
    unique case (len)
      LEN_WORD: span = 8'h0F;
      LEN_1B:   span = 8'h01;
      LEN_2B:   span = 8'h03;
      default:  span = 8'h07;
    endcase
    span = span << offset;
    return span[3:0];
  endfunction

endpackage

// File: rtl/mem_responder_sync_fifo.sv
// sync_fifo: generic synchronous FIFO with a registered head output.
// Pushes when full and pops when empty are ignored. Storage is not reset;
// pointers, count and head register are (synchronous, active-low).
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             do_push, do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = head_q;

  // Next pointers/count; head forwards the incoming word when it lands in an empty FIFO
  always_comb begin
    wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
    if (count_d == '0) begin
      head_d = '0;
    end else if (do_push && (rd_ptr_d == wr_ptr_q)) begin
      head_d = wdata_i;
    end else begin
      head_d = mem_q[rd_ptr_d];
    end
  end

  // Control state with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

  // Storage array, intentionally not reset
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/mem_responder.sv
// mem_responder: byte-enabled word memory behind a valid/ready request port,
// returning in-order responses after LATENCY cycles through a response FIFO.
// Request admission is credit-based so the FIFO can never overflow.
// Optional MEM_RSP_RAND_STALL_EN: LFSR-driven pseudo-random req_rdy stalls.
module mem_responder
  import memory_types_pkg::*;
#(
  parameter int unsigned MEM_WORDS      = 1024,
  parameter int unsigned LATENCY        = 1,
  parameter int unsigned RSP_FIFO_DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     req_vld,
  output logic     req_rdy,
  input  mem_pkt_t req,
  output logic     rsp_vld,
  input  logic     rsp_rdy,
  output mem_pkt_t rsp
);

  localparam int unsigned IW = $clog2(MEM_WORDS);
  localparam int unsigned CW = $clog2(RSP_FIFO_DEPTH + 1);

  logic [31:0]   mem_q [MEM_WORDS];
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic          accept, pop, credit_ok;
  logic [IW-1:0] word_idx;
  logic [1:0]    offset;
  logic [3:0]    be;
  logic [31:0]   be_bits, wdata_sh, rd_data;
  mem_pkt_t      rsp_pkt;
  mem_pkt_t      push_pkt;
  logic          push_vld;
  logic          fifo_full, fifo_empty;

  assign accept    = req_vld && req_rdy;
  assign pop       = rsp_vld && rsp_rdy;
  assign credit_ok = (outstanding_q < CW'(RSP_FIFO_DEPTH));

`ifdef MEM_RSP_RAND_STALL_EN
  logic [7:0] lfsr_q;

  // Fibonacci LFSR, taps 8,6,5,4, free-running every cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr_q <= 8'hA5;
    end else begin
      lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
  end

  assign req_rdy = rst_n && credit_ok && (lfsr_q[1:0] != 2'b00);
`else
  assign req_rdy = rst_n && credit_ok;
`endif

  // Decode the access and build the response packet from the current array contents
  always_comb begin
    word_idx = req.addr[2 +: IW];
    offset   = req.addr[1:0];
    be       = len_to_bytemask(req.len, offset);
    be_bits  = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    wdata_sh = req.data << {offset, 3'b000};
    rd_data  = (mem_q[word_idx] & be_bits) >> {offset, 3'b000};
    rsp_pkt       = req;
    rsp_pkt.data  = (req.mtype == READ) ? rd_data : '0;
  end

  // Byte-enabled write at the accept edge; contents survive reset
  always_ff @(posedge clk) begin
    if (accept && (req.mtype == WRITE)) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (be[b]) begin
          mem_q[word_idx][8*b +: 8] <= wdata_sh[8*b +: 8];
        end
      end
    end
  end

  generate
    if (LATENCY == 1) begin : g_direct
      assign push_vld = accept;
      assign push_pkt = rsp_pkt;
    end else begin : g_pipe
      logic     stg_vld_q [LATENCY-1];
      mem_pkt_t stg_pkt_q [LATENCY-1];

      // Non-stalling delay line; only the valid tags are reset
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int unsigned i = 0; i < LATENCY - 1; i++) begin
            stg_vld_q[i] <= 1'b0;
          end
        end else begin
          stg_vld_q[0] <= accept;
          for (int unsigned i = 1; i < LATENCY - 1; i++) begin
            stg_vld_q[i] <= stg_vld_q[i-1];
          end
        end
        stg_pkt_q[0] <= rsp_pkt;
        for (int unsigned i = 1; i < LATENCY - 1; i++) begin
          stg_pkt_q[i] <= stg_pkt_q[i-1];
        end
      end

      assign push_vld = stg_vld_q[LATENCY-2];
      assign push_pkt = stg_pkt_q[LATENCY-2];
    end
  endgenerate

  // Credit counter: +1 on accept, -1 on pop, unchanged when both
  always_comb begin
    outstanding_d = outstanding_q;
    if (accept && !pop) begin
      outstanding_d = outstanding_q + 1'b1;
    end else if (!accept && pop) begin
      outstanding_d = outstanding_q - 1'b1;
    end
  end

  // Credit counter register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      outstanding_q <= '0;
    end else begin
      outstanding_q <= outstanding_d;
    end
  end

  sync_fifo #(
    .WIDTH ($bits(mem_pkt_t)),
    .DEPTH (RSP_FIFO_DEPTH)
  ) u_rsp_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_vld),
    .wdata_i (push_pkt),
    .pop_i   (pop),
    .rdata_o (rsp),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign rsp_vld = !fifo_empty;

  // The credit limit must keep pushes away from a full FIFO
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push_vld && fifo_full));

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder (MEM_WORDS=256, LATENCY=2, RSP_FIFO_DEPTH=4).
module tb_mem_responder;
  import memory_types_pkg::*;

  logic     clk = 1'b0;
  logic     rst_n, req_vld, req_rdy, rsp_vld, rsp_rdy;
  mem_pkt_t req, rsp;

  int checks = 0;
  int failures = 0;
  int acc_cnt = 0;
  int pop_cnt = 0;
  int dropped = 0;
  int zero_out_stalls = 0;
  bit rand_mode = 1'b0;
  mem_pkt_t exp_q[$];
  mem_pkt_t mon_e;

  always #5 clk = ~clk;

  mem_responder #(
    .MEM_WORDS      (256),
    .LATENCY        (2),
    .RSP_FIFO_DEPTH (4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_vld (req_vld),
    .req_rdy (req_rdy),
    .req     (req),
    .rsp_vld (rsp_vld),
    .rsp_rdy (rsp_rdy),
    .rsp     (rsp)
  );

  function automatic mem_pkt_t mk(input mem_type_e t, input logic [31:0] a,
                                  input logic [1:0] l, input logic [31:0] d);
    mem_pkt_t p;
    p.mtype = t;
    p.addr  = a;
    p.len   = l;
    p.data  = d;
    return p;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever a response is handed over
  always @(negedge clk) begin
    if (rst_n) begin
      if (rand_mode && ((acc_cnt - pop_cnt - dropped) == 0) && !req_rdy) begin
        zero_out_stalls++;
      end
      if (rsp_vld && rsp_rdy) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rsp_unexpected: got %h expected no response", rsp);
        end else begin
          mon_e = exp_q.pop_front();
          check("rsp_pkt", rsp, mon_e);
        end
        pop_cnt++;
      end
    end
  end

  // Present one request until accepted, then push its expected response
  task automatic send(input mem_pkt_t p, input mem_pkt_t e);
    bit acc;
    acc = 1'b0;
    req = p;
    req_vld = 1'b1;
    for (int i = 0; i < 300 && !acc; i++) begin
      @(negedge clk);
      acc = req_rdy;
      if (acc) exp_q.push_back(e);
      @(posedge clk);
      #1;
      if (acc) acc_cnt++;
      if (rand_mode) rsp_rdy = ($urandom_range(0, 3) != 0);
    end
    req_vld = 1'b0;
    req = '0;
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL req_accept_timeout: got no accept expected accept for addr %h", p.addr);
    end
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !rsp_vld) done = 1'b1;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  mem_pkt_t bp_req [5];
  mem_pkt_t bp_exp [5];

  initial begin
    logic [7:0]  mm [8][4];
    int unsigned w, n, acc_n, stale;
    logic [1:0]  off, ln;
    logic [31:0] d, a, rd;
    mem_type_e   t;

    rst_n = 1'b0;
    req_vld = 1'b0;
    req = '0;
    rsp_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_req_rdy", req_rdy, 1'b0);
    check("reset_rsp_vld", rsp_vld, 1'b0);
    check("reset_rsp", rsp, '0);
    rst_n = 1'b1;
    @(negedge clk);
    check("req_rdy_after_reset", req_rdy, 1'b1);
    @(posedge clk);
    #1;

    // Word write then read, with latency check
    send(mk(WRITE, 32'h10, 2'd0, 32'hDEADBEEF), mk(WRITE, 32'h10, 2'd0, 32'h0));
    drain();
    send(mk(READ, 32'h10, 2'd0, 32'h0), mk(READ, 32'h10, 2'd0, 32'hDEADBEEF));
    @(negedge clk);
    check("latency_cycle1_rsp_vld", rsp_vld, 1'b0);
    @(negedge clk);
    check("latency_cycle2_rsp_vld", rsp_vld, 1'b1);
    drain();

    // Byte write and sub-word reads
    send(mk(WRITE, 32'h11, 2'd1, 32'h000000AA), mk(WRITE, 32'h11, 2'd1, 32'h0));
    send(mk(READ, 32'h10, 2'd0, 32'h0), mk(READ, 32'h10, 2'd0, 32'hDEADAAEF));
    send(mk(READ, 32'h13, 2'd1, 32'h0), mk(READ, 32'h13, 2'd1, 32'h000000DE));
    send(mk(READ, 32'h12, 2'd2, 32'h0), mk(READ, 32'h12, 2'd2, 32'h0000DEAD));

    // Boundary crossing and address wrap
    send(mk(WRITE, 32'h14, 2'd0, 32'h55667788), mk(WRITE, 32'h14, 2'd0, 32'h0));
    send(mk(WRITE, 32'h13, 2'd2, 32'h00001234), mk(WRITE, 32'h13, 2'd2, 32'h0));
    send(mk(READ, 32'h10, 2'd0, 32'h0), mk(READ, 32'h10, 2'd0, 32'h34ADAAEF));
    send(mk(READ, 32'h14, 2'd0, 32'h0), mk(READ, 32'h14, 2'd0, 32'h55667788));
    send(mk(READ, 32'h13, 2'd3, 32'h0), mk(READ, 32'h13, 2'd3, 32'h00000034));
    send(mk(WRITE, 32'h400, 2'd0, 32'h11111111), mk(WRITE, 32'h400, 2'd0, 32'h0));
    send(mk(READ, 32'h0, 2'd0, 32'h0), mk(READ, 32'h0, 2'd0, 32'h11111111));
    drain();

    // Backpressure: FIFO depth limits acceptance
    bp_req[0] = mk(READ, 32'h10, 2'd0, 32'h0); bp_exp[0] = mk(READ, 32'h10, 2'd0, 32'h34ADAAEF);
    bp_req[1] = mk(READ, 32'h14, 2'd0, 32'h0); bp_exp[1] = mk(READ, 32'h14, 2'd0, 32'h55667788);
    bp_req[2] = mk(READ, 32'h0,  2'd0, 32'h0); bp_exp[2] = mk(READ, 32'h0,  2'd0, 32'h11111111);
    bp_req[3] = mk(READ, 32'h15, 2'd2, 32'h0); bp_exp[3] = mk(READ, 32'h15, 2'd2, 32'h00006677);
    bp_req[4] = mk(READ, 32'h13, 2'd1, 32'h0); bp_exp[4] = mk(READ, 32'h13, 2'd1, 32'h00000034);
    rsp_rdy = 1'b0;
    acc_n = 0;
    for (int c = 0; c < 10; c++) begin
      req_vld = 1'b1;
      req = bp_req[(acc_n < 5) ? acc_n : 4];
      @(negedge clk);
      if (req_rdy && acc_n < 5) begin
        exp_q.push_back(bp_exp[acc_n]);
        acc_n++;
      end
      @(posedge clk);
      #1;
    end
    req_vld = 1'b0;
    req = '0;
    acc_cnt += acc_n;
    check("bp_accepted", acc_n, 4);
    @(negedge clk);
    check("bp_req_rdy_full", req_rdy, 1'b0);
    @(posedge clk);
    #1;
    rsp_rdy = 1'b1;
    @(negedge clk);
    check("bp_req_rdy_pop_cycle", req_rdy, 1'b0);
    @(negedge clk);
    check("bp_req_rdy_after_pop", req_rdy, 1'b1);
    drain();

    // Reset with reads in flight
    rsp_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send(mk(READ, 32'h0, 2'd0, 32'h0), mk(READ, 32'h0, 2'd0, 32'h11111111));
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midreset_rsp_vld", rsp_vld, 1'b0);
    check("midreset_req_rdy", req_rdy, 1'b0);
    check("midreset_rsp", rsp, '0);
    rst_n = 1'b1;
    exp_q.delete();
    dropped = acc_cnt - pop_cnt;
    rsp_rdy = 1'b1;
    @(negedge clk);
    check("post_reset_req_rdy", req_rdy, 1'b1);
    stale = 0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_vld) stale++;
    end
    check("post_reset_no_stale", stale, 0);
    @(posedge clk);
    #1;
    send(mk(READ, 32'h10, 2'd0, 32'h0), mk(READ, 32'h10, 2'd0, 32'h34ADAAEF));
    send(mk(READ, 32'h400, 2'd0, 32'h0), mk(READ, 32'h400, 2'd0, 32'h11111111));
    drain();

    // Random traffic against a byte-level model on words 0..7
    rand_mode = 1'b1;
    for (int unsigned i = 0; i < 8; i++) begin
      d = $urandom;
      for (int unsigned k = 0; k < 4; k++) mm[i][k] = d[8*k +: 8];
      send(mk(WRITE, i << 2, 2'd0, d), mk(WRITE, i << 2, 2'd0, 32'h0));
    end
    for (int i = 0; i < 200; i++) begin
      w   = $urandom_range(0, 7);
      off = 2'($urandom_range(0, 3));
      ln  = 2'($urandom_range(0, 3));
      d   = $urandom;
      t   = ($urandom_range(0, 1) == 1) ? WRITE : READ;
      a   = ($urandom & 32'hFFFF_FC00) | (w << 2) | 32'(off);
      n   = (ln == 2'd0) ? 4 : 32'(ln);
      rd  = '0;
      for (int unsigned k = 0; k < n; k++) begin
        if (off + k < 4) begin
          if (t == WRITE) mm[w][off + k] = d[8*k +: 8];
          else rd[8*k +: 8] = mm[w][off + k];
        end
      end
      send(mk(t, a, ln, d), mk(t, a, ln, rd));
    end
    rand_mode = 1'b0;
    rsp_rdy = 1'b1;
    drain();

`ifdef MEM_RSP_RAND_STALL_EN
    check("stall_seen_at_zero_outstanding", (zero_out_stalls > 0), 1'b1);
`else
    check("no_stall_at_zero_outstanding", zero_out_stalls, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_responder.md
# mem_responder

Synchronous memory responder that terminates one `mem_pkt_t` request/response port, the slave end of the port the RV32I core drives for imem and dmem. It accepts READ/WRITE requests over a valid/ready handshake, performs the access on a word-organised byte-enabled array, and returns in-order responses after a fixed pipeline latency. A response FIFO with credit-based request admission lets the block absorb response backpressure without ever dropping a response. It serves as the instruction or data memory in the core testbench and in the FPGA top level.

## Interface
- `MEM_WORDS`, 1024: number of 32-bit words; must be a power of two.
- `LATENCY`, 1: request-accept to earliest response-valid, in cycles; must be ≥1.
- `RSP_FIFO_DEPTH`, 4: maximum number of outstanding responses; must be ≥1.
- `clk` in 1: the single clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `req_vld` in 1: a request is presented.
- `req_rdy` out 1: the block can accept a request this cycle.
- `req` in `$bits(mem_pkt_t)`: request packet (`mtype`, `addr`, `len`, `data`).
- `rsp_vld` out 1: the response at the head is valid.
- `rsp_rdy` in 1: the consumer accepts the response.
- `rsp` out `$bits(mem_pkt_t)`: response packet.

## Operation
- A request is accepted when `req_vld && req_rdy` at a rising edge. A response is popped when `rsp_vld && rsp_rdy`.
- **Length encoding** (`len`): 0 means 4 bytes, 1 means 1 byte, 2 means 2 bytes, 3 means 3 bytes. The byte offset is `addr[1:0]`.
- **Word index** is `addr[2 +: $clog2(MEM_WORDS)]`. Upper address bits are ignored, so addresses wrap modulo `MEM_WORDS*4`.
- **Byte enables** cover bytes `addr[1:0]` through `addr[1:0]+nbytes-1`, clipped at byte 3. An access that crosses a word boundary touches only the bytes within the addressed word. No error is signalled.
- **WRITE**
  - Enabled bytes take `req.data` in little-endian order, LSB first, shifted to the offset. The array updates at the accept edge.
  - The response carries `mtype=WRITE`, `addr` and `len` echoed, and `data=0`.
- **READ**
  - The enabled bytes are read at the accept edge, right-aligned and zero-extended into `data`. Unenabled bytes read as 0.
  - `mtype`, `addr` and `len` are echoed.
  - Sign extension is the requester's job.
- **Ordering**: responses return strictly in acceptance order. A READ accepted after a WRITE to the same word observes the WRITE.
- **Credit counter** `outstanding`
  - Width is `$clog2(RSP_FIFO_DEPTH+1)`.
  - It increments on accept and decrements on pop. Accept and pop in the same cycle leave it unchanged.
  - `req_rdy = rst_n && outstanding < RSP_FIFO_DEPTH`. `req_rdy` is registered-state based and does not depend combinationally on `req_vld` or `rsp_rdy`.
- **Response path**
  - Stages 1..`LATENCY-1` are plain valid-tagged registers that never stall. At `LATENCY` the response is written into the FIFO.
  - The credit rule guarantees the FIFO never overflows.
  - `rsp_vld` is high while the FIFO is non-empty, and `rsp` is the FIFO head.
- **Reset** (while `rst_n=0` at an edge)
  - `req_rdy=0`, `rsp_vld=0`, `rsp=0`, `outstanding=0`.
  - The FIFO is emptied and pipeline valids are cleared, so in-flight requests and responses are dropped.
  - Array contents are not reset. They are retained across reset and undefined at power-up.

## Timing
- A request accepted at edge E0 writes the FIFO at edge E(`LATENCY`-1), so `rsp_vld` is high from cycle `LATENCY` when the FIFO was empty.
- With `rsp_rdy` held at 1: one request per cycle is sustained and response throughput is 1 per cycle.
- With `outstanding==RSP_FIFO_DEPTH` and a pop in the current cycle: `req_rdy` stays 0 in that cycle and rises in the next cycle.
- First cycle after reset deasserts: `req_rdy=1` (when `MEM_RSP_RAND_STALL_EN` is not defined).

## Configuration
- `MEM_RSP_RAND_STALL_EN`
  - **Defined**: an 8-bit Fibonacci LFSR (taps 8,6,5,4; reset seed 8'hA5) advances every cycle. `req_rdy` is additionally forced to 0 whenever `lfsr[1:0]==2'b00`, injecting deterministic pseudo-random request stalls for verification. The credit and ordering rules are unchanged.
  - **Not defined**: there is no LFSR and `req_rdy` follows the credit rule alone.

## Structure
- `memory_types_pkg` owns:
  - `mem_pkt_t` and the `READ`/`WRITE` encodings;
  - the `len` encoding constants;
  - a `len_to_bytemask(len, offset)` function returning a 4-bit mask.
- The block has one sub-module, `sync_fifo`, with parameters `WIDTH` and `DEPTH`. It provides push/pop, `full` and `empty`, a registered head output, and a synchronous active-low reset. It is reused elsewhere.
- The array, the pipeline registers and the credit counter live in `mem_responder`.

## Test plan
- **Word write then read**: `LATENCY=2`; WRITE `addr=0x10`, `len=0`, `data=0xDEADBEEF`, then READ `addr=0x10`, `len=0`. Required: the read response `data=0xDEADBEEF`, `mtype=READ`, `addr=0x10`, and `rsp_vld` rises exactly 2 cycles after the read is accepted.
- **Byte write and sub-word reads**: after the first scenario, WRITE `addr=0x11`, `len=1`, `data=0xAA`. Required:
  - READ word `0x10` returns `0xDEADAAEF`;
  - READ `addr=0x13`, `len=1` returns `0x000000DE`;
  - READ `addr=0x12`, `len=2` returns `0x0000DEAD`.
- **Backpressure**: `RSP_FIFO_DEPTH=4`, `rsp_rdy=0`, back-to-back READs. Required:
  - exactly 4 accepted, then `req_rdy=0`;
  - after raising `rsp_rdy`: the 4 responses arrive in order and `req_rdy` returns 1 the cycle after the first pop.
- **Boundary cross and wrap**:
  - `MEM_WORDS=256`; WRITE `addr=0x13`, `len=2`, `data=0x1234`. Required: only byte 3 of word 4 becomes `0x34`.
  - WRITE `addr=0x400` `0x11111111`. Required: READ `addr=0x0` returns `0x11111111`.
- **Reset mid-operation**: 3 reads in flight with `rsp_rdy=0`, then assert `rst_n=0` for one edge. Required:
  - `rsp_vld=0` and `req_rdy=0` during reset;
  - after reset: no stale responses, `req_rdy=1`, and earlier written data still reads back.
- **Stall injection**: build with `MEM_RSP_RAND_STALL_EN` and issue 200 random requests against a scoreboard. Required: every response matches the scoreboard, and `req_rdy` deasserts at least once with `outstanding==0`.
